// File: rtl/csr_def.sv
// csr_def: shared CSR definitions for the hardware performance counter bank.
//   - CSR address bases for machine counters, user shadows, mcountinhibit
//     and mhpmevent.
//   - mhpmevent field positions (selector [7:0], OF bit 31).
//   - cnt_t, the counter storage type. A package cannot take a parameter, so
//     cnt_t is sized to the widest legal counter. cnt_mask() gives the mask
//     for the width actually implemented, and every counter is held masked.
package csr_def;

  localparam logic [11:0] CSR_MCOUNTER_LO   = 12'hB00;  // mcycle/minstret/mhpmcounterN
  localparam logic [11:0] CSR_MCOUNTER_HI   = 12'hB80;  // ...h halves
  localparam logic [11:0] CSR_COUNTER_LO    = 12'hC00;  // read-only user shadows
  localparam logic [11:0] CSR_COUNTER_HI    = 12'hC80;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT     = 12'h320;  // mhpmeventN = base + N (N >= 3)

  localparam int EVT_SEL_LSB = 0;
  localparam int EVT_SEL_W   = 8;
  localparam int EVT_OF_BIT  = 31;

  localparam int CNT_MAX_W = 64;
  typedef logic [CNT_MAX_W-1:0] cnt_t;

  function automatic cnt_t cnt_mask(input int w);
    return {CNT_MAX_W{1'b1}} >> (CNT_MAX_W - w);
  endfunction

endpackage

// File: rtl/hpm_counter.sv
// hpm_counter: one machine counter with inhibit, increment, half-writes,
// wrap detection and an optional sticky overflow (OF) flag.
// Optional feature: HPM_OVERFLOW_IRQ_EN (OF flag present; otherwise of_o = 0).
// Ports:
//   clk, rst        clock, async active-high reset
//   inhibit_i       hold the count this cycle
//   inc_i           increment amount this cycle
//   we_lo_i/we_hi_i write wdata_i into the low/high 32-bit half
//   of_we_i         write of_wdata_i into OF
//   cnt_o           count value, zero above CNT_WIDTH
//   of_o            sticky overflow flag
module hpm_counter
  import csr_def::*;
#(
  parameter int CNT_WIDTH = 64,
  parameter int INC_W     = 2,
  parameter bit HAS_OF    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inhibit_i,
  input  logic [INC_W-1:0] inc_i,
  input  logic             we_lo_i,
  input  logic             we_hi_i,
  input  logic [31:0]      wdata_i,
  input  logic             of_we_i,
  input  logic             of_wdata_i,
  output cnt_t             cnt_o,
  output logic             of_o
);

  localparam cnt_t MASK = cnt_mask(CNT_WIDTH);

  cnt_t             cnt_q, cnt_d;
  logic [CNT_MAX_W:0] sum;
  logic             wrap;

  // A write to either half takes the place of this cycle's increment, and
  // only touches the written half, so no carry crosses from the write.
  always_comb begin
    sum   = {1'b0, cnt_q} + {{(CNT_MAX_W+1-INC_W){1'b0}}, inc_i};
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (we_lo_i)
      cnt_d = {cnt_q[63:32], wdata_i} & MASK;
    else if (we_hi_i)
      cnt_d = {wdata_i, cnt_q[31:0]} & MASK;
    else if (!inhibit_i) begin
      cnt_d = sum[CNT_MAX_W-1:0] & MASK;
      // cnt_q never exceeds MASK, so any bit at or above CNT_WIDTH means wrap.
      wrap  = |(sum >> CNT_WIDTH);
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;

  assign cnt_o = cnt_q;

`ifdef HPM_OVERFLOW_IRQ_EN
  logic of_q, of_d;

  // A wrap beats a software clear landing in the same cycle.
  always_comb begin
    of_d = of_q;
    if (of_we_i)         of_d = of_wdata_i;
    if (HAS_OF && wrap)  of_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) of_q <= 1'b0;
    else     of_q <= of_d;

  assign of_o = of_q;
`else
  logic unused_of;
  assign unused_of = of_we_i ^ of_wdata_i ^ wrap ^ HAS_OF;
  assign of_o      = 1'b0;
`endif

endmodule

// File: rtl/hpm_counter_bank.sv
// hpm_counter_bank: mcycle, minstret and NUM_HPM programmable counters with
// mcountinhibit, mhpmevent selectors and a counter-overflow interrupt.
// Optional feature: HPM_OVERFLOW_IRQ_EN (mhpmevent OF bits and lcofi_irq).
// Ports:
//   clk, rst     clock, async active-high reset
//   csr_raddr    CSR read address; csr_rdata/csr_rhit are combinational
//   csr_waddr, csr_we, csr_wdata   CSR write port
//   retire_cnt   instructions retired this cycle (minstret increment)
//   events       per-cycle event pulses; selector k counts events[k-1]
//   lcofi_irq    registered OR of all OF bits
module hpm_counter_bank
  import csr_def::*;
#(
  parameter int NUM_HPM    = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_EVENTS = 16,
  parameter int RETIRE_W   = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [11:0]                     csr_raddr,
  output logic [31:0]                     csr_rdata,
  output logic                            csr_rhit,
  input  logic [11:0]                     csr_waddr,
  input  logic                            csr_we,
  input  logic [31:0]                     csr_wdata,
  input  logic [$clog2(RETIRE_W+1)-1:0]   retire_cnt,
  input  logic [NUM_EVENTS-1:0]           events,
  output logic                            lcofi_irq
);

  localparam int NCNT = NUM_HPM + 2;
  localparam int RW   = $clog2(RETIRE_W + 1);
  // Implemented inhibit bits: CY (0), IR (2), HPM3..3+NUM_HPM-1.
  localparam logic [31:0] INH_MASK = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);

  // Counter slot g holds CSR index 0 (mcycle), 2 (minstret), then 3, 4, ...
  function automatic logic [11:0] slot_idx(input int g);
    return (g == 0) ? 12'd0 : 12'(g + 1);
  endfunction

  logic [31:0]     inh_q;
  logic [7:0]      sel_q [NUM_HPM];
  cnt_t            cnt   [NCNT];
  logic [NCNT-1:0] of;
  logic [255:0]    ev_pad;

  // Bit 0 is the "never count" slot, so ev_pad[sel] is the selected event
  // and any selector past NUM_EVENTS lands on a zero bit.
  assign ev_pad = 256'({events, 1'b0});

  always_ff @(posedge clk or posedge rst)
    if (rst)                                          inh_q <= '0;
    else if (csr_we && csr_waddr == CSR_MCOUNTINHIBIT) inh_q <= csr_wdata & INH_MASK;

  for (genvar h = 0; h < NUM_HPM; h++) begin : g_evt
    always_ff @(posedge clk or posedge rst)
      if (rst)
        sel_q[h] <= '0;
      else if (csr_we && csr_waddr == CSR_MHPMEVENT + 12'(h + 3))
        sel_q[h] <= csr_wdata[EVT_SEL_LSB +: EVT_SEL_W];
  end

  for (genvar g = 0; g < NCNT; g++) begin : g_cnt
    logic [RW-1:0] inc;
    logic          of_we;

    if (g == 0)      begin : g_cy assign inc = RW'(1);                   end
    else if (g == 1) begin : g_ir assign inc = retire_cnt;               end
    else             begin : g_hp assign inc = RW'(ev_pad[sel_q[g-2]]); end

    assign of_we = (g >= 2) && csr_we && (csr_waddr == CSR_MHPMEVENT + slot_idx(g));

    hpm_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .INC_W     (RW),
      .HAS_OF    (g >= 2)
    ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .inhibit_i  (inh_q[slot_idx(g)]),
      .inc_i      (inc),
      .we_lo_i    (csr_we && csr_waddr == CSR_MCOUNTER_LO + slot_idx(g)),
      .we_hi_i    (csr_we && csr_waddr == CSR_MCOUNTER_HI + slot_idx(g)),
      .wdata_i    (csr_wdata),
      .of_we_i    (of_we),
      .of_wdata_i (csr_wdata[EVT_OF_BIT]),
      .cnt_o      (cnt[g]),
      .of_o       (of[g])
    );
  end

  always_comb begin
    csr_rdata = '0;
    csr_rhit  = 1'b0;
    if (csr_raddr == CSR_MCOUNTINHIBIT) begin
      csr_rdata = inh_q;
      csr_rhit  = 1'b1;
    end
    for (int g = 0; g < NCNT; g++) begin
      if (csr_raddr == CSR_MCOUNTER_LO + slot_idx(g) ||
          csr_raddr == CSR_COUNTER_LO  + slot_idx(g)) begin
        csr_rdata = cnt[g][31:0];
        csr_rhit  = 1'b1;
      end
      if (csr_raddr == CSR_MCOUNTER_HI + slot_idx(g) ||
          csr_raddr == CSR_COUNTER_HI  + slot_idx(g)) begin
        csr_rdata = cnt[g][63:32];
        csr_rhit  = 1'b1;
      end
      if (g >= 2 && csr_raddr == CSR_MHPMEVENT + slot_idx(g)) begin
        csr_rdata                             = '0;
        csr_rdata[EVT_SEL_LSB +: EVT_SEL_W]   = sel_q[(g >= 2) ? g - 2 : 0];
        csr_rdata[EVT_OF_BIT]                 = of[g];
        csr_rhit                              = 1'b1;
      end
    end
  end

`ifdef HPM_OVERFLOW_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) irq_q <= 1'b0;
    else     irq_q <= |of;
  assign lcofi_irq = irq_q;
`else
  logic unused_irq;
  assign unused_irq = |of;
  assign lcofi_irq  = 1'b0;
`endif

endmodule

// File: tb/tb_hpm_counter_bank.sv
`timescale 1ns/10ps
module tb_hpm_counter_bank;

  localparam int NUM_HPM    = 1;
  localparam int CNT_WIDTH  = 64;
  localparam int NUM_EVENTS = 16;
  localparam int RETIRE_W   = 2;
  localparam int RW         = $clog2(RETIRE_W + 1);
`ifdef HPM_OVERFLOW_IRQ_EN
  localparam bit OFV = 1'b1;
`else
  localparam bit OFV = 1'b0;
`endif
  localparam logic [31:0] EV3_OF = OFV ? 32'h8000_0001 : 32'h0000_0001;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [11:0]           csr_raddr = '0;
  logic [31:0]           csr_rdata;
  logic                  csr_rhit;
  logic [11:0]           csr_waddr = '0;
  logic                  csr_we = 1'b0;
  logic [31:0]           csr_wdata = '0;
  logic [RW-1:0]         retire_cnt = '0;
  logic [NUM_EVENTS-1:0] events = '0;
  logic                  lcofi_irq;

  always #5 clk = ~clk;

  hpm_counter_bank #(
    .NUM_HPM(NUM_HPM), .CNT_WIDTH(CNT_WIDTH),
    .NUM_EVENTS(NUM_EVENTS), .RETIRE_W(RETIRE_W)
  ) dut (
    .clk(clk), .rst(rst),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_rhit(csr_rhit),
    .csr_waddr(csr_waddr), .csr_we(csr_we), .csr_wdata(csr_wdata),
    .retire_cnt(retire_cnt), .events(events), .lcofi_irq(lcofi_irq)
  );

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic        hit;
  } rd_t;

  rd_t sb[$];
  int  passed = 0;
  int  total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
  endtask

  // Expected read result goes on the scoreboard, the DUT is addressed, and
  // the combinational response is popped and compared a moment later.
  task automatic rd(input logic [11:0] a, input logic [31:0] d, input logic h);
    rd_t r;
    r.addr = a; r.data = d; r.hit = h;
    sb.push_back(r);
    csr_raddr = a;
    #0.1;
    r = sb.pop_front();
    chk($sformatf("rdata@%03h", r.addr), csr_rdata, r.data);
    chk($sformatf("rhit@%03h", r.addr), {31'b0, csr_rhit}, {31'b0, r.hit});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_waddr = a; csr_wdata = d; csr_we = 1'b1;
    tick();
    csr_we = 1'b0;
  endtask

  rd_t tbl [13];

  initial begin
    tbl[0]  = '{12'hB00, 32'd10, 1'b1};
    tbl[1]  = '{12'hB80, 32'd0,  1'b1};
    tbl[2]  = '{12'hC00, 32'd10, 1'b1};
    tbl[3]  = '{12'hC80, 32'd0,  1'b1};
    tbl[4]  = '{12'hB02, 32'd0,  1'b1};
    tbl[5]  = '{12'hB01, 32'd0,  1'b0};
    tbl[6]  = '{12'hB03, 32'd0,  1'b1};
    tbl[7]  = '{12'hC04, 32'd0,  1'b0};
    tbl[8]  = '{12'hB84, 32'd0,  1'b0};
    tbl[9]  = '{12'h320, 32'd0,  1'b1};
    tbl[10] = '{12'h323, 32'd0,  1'b1};
    tbl[11] = '{12'h324, 32'd0,  1'b0};
    tbl[12] = '{12'h7FF, 32'd0,  1'b0};

    // reset state
    rd(12'hB00, 32'd0, 1'b1);
    rd(12'h320, 32'd0, 1'b1);
    chk("irq_in_reset", {31'b0, lcofi_irq}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) tick();

    // decode table after 10 free-running cycles
    for (int i = 0; i < 13; i++) rd(tbl[i].addr, tbl[i].data, tbl[i].hit);

    // inhibit CY and IR
    wr(12'h320, 32'h5);
    retire_cnt = 2'd2;
    repeat (4) tick();
    retire_cnt = '0;
    rd(12'hB00, 32'd11, 1'b1);
    rd(12'hB02, 32'd0,  1'b1);
    rd(12'h320, 32'h5,  1'b1);
    wr(12'h320, 32'hFFFF_FFFF);
    rd(12'h320, 32'hD,  1'b1);

    // minstret counts retire_cnt once IR is released
    wr(12'h320, 32'h1);
    retire_cnt = 2'd2;
    repeat (3) tick();
    retire_cnt = 2'd1;
    tick();
    retire_cnt = '0;
    rd(12'hB02, 32'd7,  1'b1);
    rd(12'hC02, 32'd7,  1'b1);
    rd(12'hB00, 32'd11, 1'b1);

    // write beats increment; other counter still increments
    wr(12'h320, 32'h0);
    retire_cnt = 2'd1;
    wr(12'hB00, 32'h100);
    retire_cnt = '0;
    rd(12'hB00, 32'h100, 1'b1);
    rd(12'hB02, 32'd8,   1'b1);
    tick();
    rd(12'hB00, 32'h101, 1'b1);

    // half writes leave the other half alone; normal carry crosses halves
    wr(12'hB80, 32'h12);
    rd(12'hB00, 32'h101, 1'b1);
    rd(12'hB80, 32'h12,  1'b1);
    wr(12'hB00, 32'hFFFF_FFFF);
    tick();
    rd(12'hB00, 32'h0,  1'b1);
    rd(12'hB80, 32'h13, 1'b1);
    wr(12'h320, 32'h1);

    // counter3 wrap and OF
    wr(12'hB03, 32'hFFFF_FFFF);
    wr(12'hB83, 32'hFFFF_FFFF);
    wr(12'h323, 32'h1);
    rd(12'hB03, 32'hFFFF_FFFF, 1'b1);
    rd(12'hB83, 32'hFFFF_FFFF, 1'b1);
    rd(12'h323, 32'h1, 1'b1);
    events = 16'h0001;
    tick();
    events = '0;
    rd(12'hB03, 32'h0, 1'b1);
    rd(12'hB83, 32'h0, 1'b1);
    rd(12'h323, EV3_OF, 1'b1);
    chk("irq_same_edge", {31'b0, lcofi_irq}, 32'd0);
    tick();
    chk("irq_next", {31'b0, lcofi_irq}, {31'b0, OFV});
    tick();
    chk("irq_sticky", {31'b0, lcofi_irq}, {31'b0, OFV});
    wr(12'h323, 32'h1);
    rd(12'h323, 32'h1, 1'b1);
    tick();
    chk("irq_cleared", {31'b0, lcofi_irq}, 32'd0);

    // wrap in the same cycle as an OF clear leaves OF set
    wr(12'hB03, 32'hFFFF_FFFF);
    wr(12'hB83, 32'hFFFF_FFFF);
    events = 16'h0001;
    wr(12'h323, 32'h1);
    events = '0;
    rd(12'h323, EV3_OF, 1'b1);
    rd(12'hB03, 32'h0,  1'b1);

    // shadows are read-only
    events = 16'h0001;
    repeat (2) tick();
    events = '0;
    rd(12'hC03, 32'd2, 1'b1);
    rd(12'hC83, 32'd0, 1'b1);
    wr(12'hC03, 32'h55);
    rd(12'hB03, 32'd2, 1'b1);
    rd(12'hC04, 32'd0, 1'b0);

    // selector range: 17 never counts, 16 counts events[15]
    wr(12'h323, 32'd17);
    events = '1;
    tick();
    events = '0;
    rd(12'hB03, 32'd2, 1'b1);
    wr(12'h323, 32'd16);
    events = 16'h8000;
    tick();
    events = '0;
    rd(12'hB03, 32'd3,  1'b1);
    rd(12'h323, 32'h10, 1'b1);

    // reset while counting with OF and irq set
    wr(12'hB03, 32'hFFFF_FFFF);
    wr(12'hB83, 32'hFFFF_FFFF);
    events = 16'h8000;
    repeat (2) tick();
    chk("irq_before_rst", {31'b0, lcofi_irq}, {31'b0, OFV});
    rst = 1'b1;
    rd(12'hB03, 32'd0, 1'b1);
    rd(12'hB00, 32'd0, 1'b1);
    rd(12'hB02, 32'd0, 1'b1);
    rd(12'h323, 32'd0, 1'b1);
    rd(12'h320, 32'd0, 1'b1);
    chk("irq_in_rst", {31'b0, lcofi_irq}, 32'd0);
    tick();
    rst = 1'b0;
    events = '0;
    tick();
    rd(12'hB03, 32'd0, 1'b1);
    chk("irq_after_rst", {31'b0, lcofi_irq}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hpm_counter_bank.md
HPM_COUNTER_BANK -- requirements
Module: hpm_counter_bank

Interface
REQ-001 The block SHALL take parameter NUM_HPM, default 4, the number of programmable counters mhpmcounter3..(3+NUM_HPM-1), legal 1..29.
REQ-002 The block SHALL take parameter CNT_WIDTH, default 64, the implemented counter width, legal 33..64.
REQ-003 The block SHALL take parameter NUM_EVENTS, default 16, the event input count, legal 1..255.
REQ-004 The block SHALL take parameter RETIRE_W, default 2, the maximum instructions retired per cycle.
REQ-005 Reset SHALL be rst, asynchronous, active-high; clock SHALL be clk.
REQ-006 The ports SHALL be the following, in this order:
- clk  in  1  clock
- rst  in  1  async active-high reset
- csr_raddr  in  12  CSR read address
- csr_rdata  out  32  read data, combinational
- csr_rhit  out  1  csr_raddr maps to an implemented counter CSR
- csr_waddr  in  12  CSR write address
- csr_we  in  1  write strobe
- csr_wdata  in  32  write data
- retire_cnt  in  $clog2(RETIRE_W+1)  instructions retired this cycle
- events  in  NUM_EVENTS  per-cycle event pulses
- lcofi_irq  out  1  counter-overflow interrupt request

Function
REQ-007 The block SHALL implement mcycle (index 0), minstret (index 2) and mhpmcounter3+ (index i); index 1 is unimplemented and reads zero.
REQ-008 The low halves SHALL be at 0xB00+i and the high halves at 0xB80+i, both read/write; the read-only shadows SHALL be at 0xC00+i and 0xC80+i.
REQ-009 mcountinhibit SHALL be at 0x320, with bits {0, 2, 3..3+NUM_HPM-1} writable and all other bits reading zero.
REQ-010 mhpmevent(i) SHALL be at 0x320+i, with bits [7:0] as the event selector and bit 31 as OF.
REQ-011 Selector 0 or any selector greater than NUM_EVENTS SHALL never count; selector k SHALL count events[k-1].
REQ-012 On each cycle where the counter's inhibit bit is 0:
- mcycle SHALL increment by 1
- minstret SHALL increment by retire_cnt
- mhpmcounter(i) SHALL increment by 1 when its selected event is high
REQ-013 The new count SHALL be visible on csr_rdata in the cycle after the increment.
REQ-014 A write to a counter half SHALL update only that half, truncated to CNT_WIDTH.
REQ-015 A written counter SHALL NOT increment in the write cycle.
REQ-016 A write to one half SHALL leave the other half unchanged, with no carry propagated from the write.
REQ-017 Bits at or above CNT_WIDTH SHALL read as zero.
REQ-018 Counters SHALL wrap from 2^CNT_WIDTH-1 to 0.
REQ-019 csr_rdata SHALL be zero and csr_rhit SHALL be 0 for any unmapped address, including counters at or above 3+NUM_HPM.
REQ-020 Writes to read-only shadow addresses or unmapped addresses SHALL be ignored.
REQ-021 A write and an increment to different counters in the same cycle SHALL both take effect.

Reset
REQ-022 On rst, all counters, all mhpmevent registers and mcountinhibit SHALL be cleared to 0.
REQ-023 On rst, lcofi_irq SHALL be 0 and csr_rhit/csr_rdata SHALL follow the address decode only.
REQ-024 A rst asserted mid-operation SHALL discard any in-flight write or increment.

Configuration
REQ-025 With HPM_OVERFLOW_IRQ_EN defined:
- mhpmcounter(i) wrapping to 0 SHALL set OF(i) on the next edge
- OF SHALL be sticky until software writes it to 0
- a wrap in the same cycle as an OF write SHALL leave OF set
- lcofi_irq SHALL be the registered OR of all OF bits
REQ-026 Without HPM_OVERFLOW_IRQ_EN, OF SHALL read zero and ignore writes, and lcofi_irq SHALL be tied to 0.

Structure
REQ-027 The CSR address constants (0xB00, 0xB80, 0xC00, 0xC80, 0x320), the mhpmevent field positions and a counter typedef sized by CNT_WIDTH SHALL live in csr_def.
REQ-028 One sub-module, hpm_counter, SHALL hold a single counter with its inhibit, increment, half-write and wrap/OF logic; the top SHALL instantiate NUM_HPM+2 copies.

Verification
REQ-029 After rst, with mcountinhibit=0 and 10 cycles elapsed, reading 0xB00 SHALL return 10 and reading 0xB80 SHALL return 0.
REQ-030 Writing 0x320 with 0x5 and then holding retire_cnt=2 for 4 cycles SHALL leave mcycle and minstret unchanged.
REQ-031 Writing 0xB03 with 0xFFFFFFFF, then 0xB83 with 0xFFFFFFFF, then mhpmevent3=1 and pulsing events[0] once SHALL make counter3 read 0. With the macro, OF3 SHALL be 1 and lcofi_irq SHALL be 1 one cycle later.
REQ-032 Writing 0xB00 with 0x100 in a cycle where mcycle would increment SHALL make the next read return 0x100.
REQ-033 Reading 0xC03 with NUM_HPM=1 SHALL return the counter value; reading 0xC04 SHALL return 0 with csr_rhit=0; writing 0xC03 SHALL have no effect.
REQ-034 Asserting rst while events[0] pulses SHALL clear all counters, OF bits and lcofi_irq.
